// File: rtl/stream_seq_checker.sv
// Stream sequence checker: compares an incoming data stream against start + n*increment.
// Optional macro STREAM_SEQ_CHECKER_BACKPRESSURE_EN throttles RUN ready with a 16-bit LFSR.
module stream_seq_checker #(
    parameter int WIDTH       = 16,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic [WIDTH-1:0]       i_in_data,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [WIDTH-1:0]       i_start_value,
    input  logic [WIDTH-1:0]       i_increment,
    input  logic [COUNT_WIDTH-1:0] i_expected_count,
    output logic [COUNT_WIDTH-1:0] o_run_count,
    output logic [COUNT_WIDTH-1:0] o_err_count,
    output logic [WIDTH-1:0]       o_first_err_data,
    output logic [WIDTH-1:0]       o_first_err_expected,
    output logic                   o_done,
    output logic                   o_pass
);

    // state | meaning
    // IDLE  | waiting for i_enable; results of the previous run held
    // RUN   | accepting and checking beats; paused while i_enable=0
    // DONE  | expected count reached; waiting for i_enable=0
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   ready_q, ready_d;
    logic [WIDTH-1:0]       expected_q, expected_d;
    logic [WIDTH-1:0]       increment_q, increment_d;
    logic [WIDTH-1:0]       first_data_q, first_data_d;
    logic [WIDTH-1:0]       first_exp_q, first_exp_d;
    logic [COUNT_WIDTH-1:0] target_q, target_d;
    logic [COUNT_WIDTH-1:0] run_count_q, run_count_d;
    logic [COUNT_WIDTH-1:0] err_count_q, err_count_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;

    logic                   gate;
    logic                   accept;
    logic                   mismatch;
    logic                   final_beat;
    logic [COUNT_WIDTH-1:0] run_count_inc;

`ifdef STREAM_SEQ_CHECKER_BACKPRESSURE_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci form, taps 16,14,13,11 expressed as right-shift bits 0,2,3,5
    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == RUN) begin
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign gate = lfsr_q[0] | lfsr_q[1];
`else
    assign gate = 1'b1;
`endif

    assign accept        = (state_q == RUN) && i_in_valid && ready_q;
    assign mismatch      = (i_in_data != expected_q);
    assign run_count_inc = run_count_q + COUNT_WIDTH'(1);
    assign final_beat    = accept && (target_q != '0) && (run_count_inc == target_q);

    always_comb begin
        state_d      = state_q;
        expected_d   = expected_q;
        increment_d  = increment_q;
        target_d     = target_q;
        run_count_d  = run_count_q;
        err_count_d  = err_count_q;
        first_data_d = first_data_q;
        first_exp_d  = first_exp_q;
        done_d       = done_q;
        pass_d       = pass_q;

        case (state_q)
            IDLE: begin
                if (i_enable) begin
                    state_d      = RUN;
                    expected_d   = i_start_value;
                    increment_d  = i_increment;
                    target_d     = i_expected_count;
                    run_count_d  = '0;
                    err_count_d  = '0;
                    first_data_d = '0;
                    first_exp_d  = '0;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                end
            end
            RUN: begin
                if (accept) begin
                    // expected advances from itself so one bad word does not resync the check
                    expected_d  = expected_q + increment_q;
                    run_count_d = run_count_inc;
                    if (mismatch) begin
                        if (err_count_q == '0) begin
                            first_data_d = i_in_data;
                            first_exp_d  = expected_q;
                        end
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + COUNT_WIDTH'(1);
                        end
                    end
                    if (final_beat) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_count_d == '0);
                    end
                end
            end
            DONE: begin
                if (!i_enable) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == RUN) && i_enable && gate;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= IDLE;
            ready_q      <= 1'b0;
            expected_q   <= '0;
            increment_q  <= '0;
            target_q     <= '0;
            run_count_q  <= '0;
            err_count_q  <= '0;
            first_data_q <= '0;
            first_exp_q  <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            expected_q   <= expected_d;
            increment_q  <= increment_d;
            target_q     <= target_d;
            run_count_q  <= run_count_d;
            err_count_q  <= err_count_d;
            first_data_q <= first_data_d;
            first_exp_q  <= first_exp_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    assign o_in_ready           = ready_q;
    assign o_run_count          = run_count_q;
    assign o_err_count          = err_count_q;
    assign o_first_err_data     = first_data_q;
    assign o_first_err_expected = first_exp_q;
    assign o_done               = done_q;
    assign o_pass               = pass_q;

endmodule

// File: tb/tb_stream_seq_checker.sv
// Bench for stream_seq_checker: index-based reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_stream_seq_checker;
    localparam int W  = 16;
    localparam int CW = 12;

    logic          i_clock = 1'b0;
    logic          i_reset;
    logic          i_enable;
    logic [W-1:0]  i_in_data;
    logic          i_in_valid;
    logic          o_in_ready;
    logic [W-1:0]  i_start_value;
    logic [W-1:0]  i_increment;
    logic [CW-1:0] i_expected_count;
    logic [CW-1:0] o_run_count;
    logic [CW-1:0] o_err_count;
    logic [W-1:0]  o_first_err_data;
    logic [W-1:0]  o_first_err_expected;
    logic          o_done;
    logic          o_pass;

    stream_seq_checker #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
        .i_clock              (i_clock),
        .i_reset              (i_reset),
        .i_enable             (i_enable),
        .i_in_data            (i_in_data),
        .i_in_valid           (i_in_valid),
        .o_in_ready           (o_in_ready),
        .i_start_value        (i_start_value),
        .i_increment          (i_increment),
        .i_expected_count     (i_expected_count),
        .o_run_count          (o_run_count),
        .o_err_count          (o_err_count),
        .o_first_err_data     (o_first_err_data),
        .o_first_err_expected (o_first_err_expected),
        .o_done               (o_done),
        .o_pass               (o_pass)
    );

    always #5 i_clock = ~i_clock;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;
    logic duty_on = 1'b0;
    int duty_run = 0;
    int duty_low = 0;

    // Reference model: expected word of beat k is start + k*inc (mod 2^W)
    int            m_mode = 0;      // 0 idle, 1 run, 2 done
    logic          m_ready = 1'b0;
    logic [W-1:0]  m_start = '0, m_inc = '0, m_fed = '0, m_fee = '0;
    logic [CW-1:0] m_target = '0, m_n = '0, m_err = '0;
    logic [31:0]   m_idx = '0;
    logic          m_done = 1'b0, m_pass = 1'b0;
    logic [15:0]   m_lfsr = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic b;
        b = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {b, s[15:1]};
    endfunction

    always @(posedge i_clock) begin : model
        logic        acc, gate;
        logic [31:0] p;
        logic [W-1:0] exp_w;
        int          nm;
        gate = 1'b1;
`ifdef STREAM_SEQ_CHECKER_BACKPRESSURE_EN
        gate = m_lfsr[0] | m_lfsr[1];
`endif
        if (i_reset) begin
            m_mode = 0; m_ready = 1'b0; m_start = '0; m_inc = '0; m_fed = '0; m_fee = '0;
            m_target = '0; m_n = '0; m_err = '0; m_idx = '0; m_done = 1'b0; m_pass = 1'b0;
            m_lfsr = 16'hACE1;
        end else begin
            acc = (m_mode == 1) && i_in_valid && m_ready;
            nm  = m_mode;
            if (m_mode == 0 && i_enable) begin
                nm = 1;
                m_start = i_start_value; m_inc = i_increment; m_target = i_expected_count;
                m_n = '0; m_idx = '0; m_err = '0; m_fed = '0; m_fee = '0;
                m_done = 1'b0; m_pass = 1'b0;
            end else if (m_mode == 1 && acc) begin
                p = 32'(m_start) + 32'(m_inc) * m_idx;
                exp_w = p[W-1:0];
                if (i_in_data != exp_w) begin
                    if (m_err == '0) begin
                        m_fed = i_in_data;
                        m_fee = exp_w;
                    end
                    if (m_err != '1) m_err = m_err + 1'b1;
                end
                m_n = m_n + 1'b1;
                m_idx = m_idx + 1;
                if (m_target != '0 && m_n == m_target) begin
                    nm = 2;
                    m_done = 1'b1;
                    m_pass = (m_err == '0);
                end
            end else if (m_mode == 2 && !i_enable) begin
                nm = 0;
            end
            m_ready = (nm == 1) && i_enable && gate;
            if (m_mode == 1) m_lfsr = lfsr_next(m_lfsr);
            m_mode = nm;
        end
    end

    always @(negedge i_clock) begin
        if (chk_en) begin
            n_cmp++;
            if ({o_in_ready, o_done, o_pass, o_run_count, o_err_count, o_first_err_data, o_first_err_expected}
                !== {m_ready, m_done, m_pass, m_n, m_err, m_fed, m_fee}) begin
                n_bad++;
                $display("FAIL model_cycle t=%0t got rdy=%b done=%b pass=%b run=%0d err=%0d fd=%h fe=%h want rdy=%b done=%b pass=%b run=%0d err=%0d fd=%h fe=%h",
                         $time, o_in_ready, o_done, o_pass, o_run_count, o_err_count, o_first_err_data,
                         o_first_err_expected, m_ready, m_done, m_pass, m_n, m_err, m_fed, m_fee);
            end
            if (duty_on && m_mode == 1) begin
                duty_run++;
                if (!o_in_ready) duty_low++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d (0x%h) want=%0d (0x%h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s got=%0d want range %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #2;
    endtask

    logic [W-1:0] words[$];

    task automatic fill_seq(input logic [W-1:0] st, input logic [W-1:0] inc, input int n);
        logic [W-1:0] v;
        words.delete();
        v = st;
        for (int k = 0; k < n; k++) begin
            words.push_back(v);
            v = v + inc;
        end
    endtask

    task automatic begin_run(input logic [W-1:0] st, input logic [W-1:0] inc, input logic [CW-1:0] cnt);
        i_start_value    = st;
        i_increment      = inc;
        i_expected_count = cnt;
        i_enable         = 1'b1;
        tick();
        // parameters are sampled only on the start edge
        i_start_value    = W'($urandom);
        i_increment      = W'($urandom);
        i_expected_count = CW'($urandom);
    endtask

    task automatic end_run();
        i_enable   = 1'b0;
        i_in_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic feed(input int gap_pct, input int err_pct, input int pause_at);
        int   i, budget, n;
        logic rdy, paused;
        i = 0; budget = 0; paused = 1'b0;
        n = words.size();
        while (i < n && budget < 20 * n + 100) begin
            if (i == pause_at && !paused) begin
                paused = 1'b1;
                i_enable = 1'b0;
                i_in_valid = 1'b0;
                tick();
                repeat (4) begin
                    i_in_valid = 1'b1;
                    i_in_data = words[i];
                    check("pause_ready", 32'(o_in_ready), 32'd0);
                    check("pause_count", 32'(o_run_count), 32'(pause_at));
                    tick();
                end
                i_enable = 1'b1;
                i_in_valid = 1'b0;
            end
            i_in_valid = ($urandom_range(99) >= gap_pct);
            i_in_data = words[i];
            if ($urandom_range(99) < err_pct) i_in_data = words[i] ^ W'(1 << $urandom_range(W - 1));
            rdy = o_in_ready;
            tick();
            if (i_in_valid && rdy) i++;
            budget++;
        end
        i_in_valid = 1'b0;
        if (i < n) begin
            n_bad++;
            n_cmp++;
            $display("FAIL feed_timeout got=%0d beats want=%0d", i, n);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog timeout at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, gp, ep, pa;
        logic [W-1:0] st, inc;
        i_reset = 1'b1; i_enable = 1'b0; i_in_valid = 1'b0; i_in_data = '0;
        i_start_value = '0; i_increment = '0; i_expected_count = '0;
        tick();
        chk_en = 1'b1;
        tick();
        check("reset_ready", 32'(o_in_ready), 32'd0);
        check("reset_run", 32'(o_run_count), 32'd0);
        check("reset_done", 32'(o_done), 32'd0);
        i_reset = 1'b0;

        // disabled: valid pulses are ignored
        for (int k = 0; k < 10; k++) begin
            i_in_valid = 1'($urandom_range(1));
            i_in_data = W'($urandom);
            tick();
        end
        i_in_valid = 1'b0;
        check("idle_ready", 32'(o_in_ready), 32'd0);
        check("idle_run", 32'(o_run_count), 32'd0);
        check("idle_done", 32'(o_done), 32'd0);

        // clean run 0..7
        begin_run(16'd0, 16'd1, 12'd8);
        fill_seq(16'd0, 16'd1, 8);
        feed(0, 0, -1);
        check("seq8_done", 32'(o_done), 32'd1);
        check("seq8_run", 32'(o_run_count), 32'd8);
        check("seq8_err", 32'(o_err_count), 32'd0);
        check("seq8_pass", 32'(o_pass), 32'd1);
        check("seq8_ready_after_last", 32'(o_in_ready), 32'd0);
        end_run();
        check("hold_done_idle", 32'(o_done), 32'd1);
        check("hold_run_idle", 32'(o_run_count), 32'd8);

        // one bad word, no resync
        begin_run(16'd0, 16'd1, 12'd8);
        words = '{16'd0, 16'd1, 16'd2, 16'd9, 16'd4, 16'd5, 16'd6, 16'd7};
        feed(0, 0, -1);
        check("bad_err", 32'(o_err_count), 32'd1);
        check("bad_first_data", 32'(o_first_err_data), 32'd9);
        check("bad_first_exp", 32'(o_first_err_expected), 32'd3);
        check("bad_pass", 32'(o_pass), 32'd0);
        check("bad_done", 32'(o_done), 32'd1);
        end_run();

        // expected value wraps at 2^W
        begin_run(16'hFFFE, 16'd1, 12'd4);
        words = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        feed(0, 0, -1);
        check("wrap_pass", 32'(o_pass), 32'd1);
        check("wrap_err", 32'(o_err_count), 32'd0);
        // valid in DONE and then IDLE is ignored
        i_in_valid = 1'b1;
        repeat (3) begin
            i_in_data = W'($urandom);
            tick();
        end
        check("done_ignore_run", 32'(o_run_count), 32'd4);
        check("done_ready", 32'(o_in_ready), 32'd0);
        i_enable = 1'b0;
        repeat (3) tick();
        check("idle_ignore_run", 32'(o_run_count), 32'd4);
        check("idle_hold_pass", 32'(o_pass), 32'd1);
        i_in_valid = 1'b0;
        tick();

        // pause mid-run
        begin_run(16'h1234, 16'h0101, 12'd20);
        fill_seq(16'h1234, 16'h0101, 20);
        feed(0, 0, 7);
        check("pause_final_run", 32'(o_run_count), 32'd20);
        check("pause_final_pass", 32'(o_pass), 32'd1);
        end_run();

        // reset mid-run clears everything
        begin_run(16'd5, 16'd3, 12'd50);
        fill_seq(16'd5, 16'd3, 3);
        feed(0, 100, -1);
        i_expected_count = 12'd10;
        i_start_value = 16'd5;
        i_increment = 16'd3;
        i_reset = 1'b1;
        tick();
        check("rst_ready", 32'(o_in_ready), 32'd0);
        check("rst_run", 32'(o_run_count), 32'd0);
        check("rst_err", 32'(o_err_count), 32'd0);
        check("rst_fd", 32'(o_first_err_data), 32'd0);
        check("rst_fe", 32'(o_first_err_expected), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_pass", 32'(o_pass), 32'd0);
        i_reset = 1'b0;
        tick();
        fill_seq(16'd5, 16'd3, 10);
        feed(20, 0, -1);
        check("fresh_run", 32'(o_run_count), 32'd10);
        check("fresh_pass", 32'(o_pass), 32'd1);
        end_run();

        // unbounded: run counter wraps, error counter saturates
        begin_run(16'd0, 16'd1, 12'd0);
        fill_seq(16'd0, 16'd1, 4200);
        feed(0, 100, -1);
        check("unb_err_sat", 32'(o_err_count), 32'hFFF);
        check("unb_run_wrap", 32'(o_run_count), 32'd104);
        check("unb_done", 32'(o_done), 32'd0);
        i_reset = 1'b1;
        i_enable = 1'b0;
        tick();
        i_reset = 1'b0;
        tick();

        // randomized runs
        for (int r = 0; r < 8; r++) begin
            cnt = $urandom_range(40, 1);
            st  = W'($urandom);
            inc = W'($urandom);
            gp  = $urandom_range(50);
            ep  = (r % 2 == 1) ? 20 : 0;
            pa  = (r % 3 == 0) ? $urandom_range(cnt - 1) : -1;
            begin_run(st, inc, CW'(cnt));
            fill_seq(st, inc, cnt);
            feed(gp, ep, pa);
            check("rand_run", 32'(o_run_count), 32'(cnt));
            check("rand_done", 32'(o_done), 32'd1);
            if (ep == 0) check("rand_pass", 32'(o_pass), 32'd1);
            end_run();
        end

        // long gapped run, ready duty in RUN
        st  = W'($urandom);
        inc = W'($urandom);
        begin_run(st, inc, 12'd1000);
        fill_seq(st, inc, 1000);
        duty_on = 1'b1;
        feed(30, 0, -1);
        duty_on = 1'b0;
        check("long_pass", 32'(o_pass), 32'd1);
        check("long_run", 32'(o_run_count), 32'd1000);
`ifdef STREAM_SEQ_CHECKER_BACKPRESSURE_EN
        check_range("ready_low_pct", (duty_low * 100) / (duty_run > 0 ? duty_run : 1), 15, 35);
`else
        check_range("ready_low_pct", (duty_low * 100) / (duty_run > 0 ? duty_run : 1), 0, 0);
`endif
        end_run();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stream_seq_checker.md
STREAM_SEQ_CHECKER -- requirements
Module: stream_seq_checker

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, meaning the stream data width.
REQ-002 The module SHALL have parameter COUNT_WIDTH, default 32, meaning the width of the beat and error counters.
REQ-003 i_clock  input  1  Clock; all logic SHALL be rising-edge.
REQ-004 i_reset  input  1  Reset; synchronous, active-high.
REQ-005 i_enable  input  1  Run enable: starts, pauses and re-arms the check.
REQ-006 i_in_data  input  WIDTH  Stream data.
REQ-007 i_in_valid  input  1  Stream valid.
REQ-008 o_in_ready  output  1  Stream ready, registered.
REQ-009 i_start_value  input  WIDTH  First expected word; sampled on the IDLE->RUN transition.
REQ-010 i_increment  input  WIDTH  Step between consecutive expected words; sampled on the IDLE->RUN transition.
REQ-011 i_expected_count  input  COUNT_WIDTH  Beats per run; 0 means unbounded; sampled on the IDLE->RUN transition.
REQ-012 o_run_count  output  COUNT_WIDTH  Beats accepted this run.
REQ-013 o_err_count  output  COUNT_WIDTH  Mismatched beats this run; saturates at all-ones.
REQ-014 o_first_err_data  output  WIDTH  Received word of the first mismatch.
REQ-015 o_first_err_expected  output  WIDTH  Expected word of the first mismatch.
REQ-016 o_done  output  1  Run complete.
REQ-017 o_pass  output  1  Run complete with zero errors.

Function
REQ-018 The module SHALL implement the states IDLE, RUN and DONE.
REQ-019 IDLE->RUN SHALL occur when i_enable=1; this transition SHALL load expected<=i_start_value and clear the counters, first-error registers, o_done and o_pass.
REQ-020 RUN->DONE SHALL occur on the handshake that makes o_run_count equal to the sampled i_expected_count, provided that count is nonzero.
REQ-021 DONE->IDLE SHALL occur when i_enable=0; results SHALL hold until the next IDLE->RUN transition.
REQ-022 In RUN with i_enable=0, o_in_ready SHALL go low the next cycle and the state SHALL remain RUN (pause).
REQ-023 A beat SHALL be accepted only on a cycle with i_in_valid=1 and o_in_ready=1.
REQ-024 o_in_ready SHALL be 0 in IDLE and DONE, and SHALL be 0 on the cycle after the final beat is accepted.
REQ-025 For each accepted beat, the module SHALL: compare i_in_data with expected; set expected<=expected+increment, wrapping modulo 2^WIDTH; and set o_run_count<=o_run_count+1.
REQ-026 Expected SHALL advance from the expected value, not the received value, so that a mismatch does not resynchronise the check.
REQ-027 On a mismatch, o_err_count SHALL increment and saturate at 2^COUNT_WIDTH-1.
REQ-028 On the first mismatch of a run only, the module SHALL capture o_first_err_data and o_first_err_expected.
REQ-029 All results SHALL update one cycle after the handshake (registered).
REQ-030 o_done SHALL assert one cycle after the final handshake.
REQ-031 o_pass SHALL equal (o_err_count==0) whenever o_done=1, and SHALL be 0 otherwise.
REQ-032 When the sampled i_expected_count is 0, the module SHALL remain in RUN indefinitely and o_run_count SHALL wrap.
REQ-033 i_in_valid asserted in IDLE or DONE SHALL be ignored and SHALL NOT count.

Reset
REQ-034 i_reset SHALL force state IDLE and set every output to 0, including o_in_ready, all counters and all first-error registers.
REQ-035 Reset asserted mid-run SHALL take effect on the next rising edge with no pending beat retained; i_enable=1 after reset SHALL start a fresh run.

Configuration
REQ-036 The module SHALL support the macro STREAM_SEQ_CHECKER_BACKPRESSURE_EN.
REQ-037 With the macro defined, the module SHALL include a 16-bit Fibonacci LFSR with taps 16,14,13,11, seed 16'hACE1, reloaded on reset.
REQ-038 With the macro defined, the LFSR SHALL advance every cycle in RUN, and RUN ready SHALL be registered (lfsr[0]|lfsr[1]), giving 75% duty.
REQ-039 Without the macro, RUN ready SHALL be constant 1, subject to REQ-022 and REQ-024, and no LFSR logic SHALL be present.

Verification
REQ-040 Scenario: reset, i_enable=0, valid pulses -> o_in_ready=0, o_run_count=0, o_done=0.
REQ-041 Scenario: start=0, inc=1, count=8, source sends 0..7 with valid held -> o_done one cycle after beat 8, o_run_count=8, o_err_count=0, o_pass=1.
REQ-042 Scenario: start=0, inc=1, count=8, source sends 0,1,2,9,4,5,6,7 -> o_err_count=1, first_err_data=9, first_err_expected=3, o_pass=0.
REQ-043 Scenario: WIDTH=16, start=16'hFFFE, inc=1, count=4, source sends FFFE,FFFF,0000,0001 -> pass.
REQ-044 Scenario: drop i_enable for 5 cycles mid-run, then resume -> no beat accepted while paused, final counts match; assert i_reset mid-run -> all outputs 0 next cycle.
REQ-045 Scenario: macro defined, count=1000 with a randomly gapped source -> pass, and o_in_ready low on roughly 25% of RUN cycles.
